// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath widths, instruction class codes
// and the writeback-stage FSM encoding.
package pipeline_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    typedef enum logic [2:0] {
        ARITH0 = 3'b000,
        ARITH1 = 3'b001,
        MEM0   = 3'b100,
        MEM1   = 3'b101,
        NOP    = 3'b111
    } type_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// M-stage to W-stage bundle: M-stage results in, regfile write port,
// stall and status out.
interface wb_stage_if #(
    parameter int unsigned DATA_W = pipeline_pkg::DATA_W,
    parameter int unsigned ADDR_W = pipeline_pkg::ADDR_W
);
    logic              ValidM;
    logic              RegWriteM;
    logic              MemtoRegM;
    logic              ByteLoadM;
    logic [ADDR_W-1:0] WA3M;
    logic [DATA_W-1:0] ALUOutM;
    logic [DATA_W-1:0] ReadDataM;
    logic              MemReadyM;
    logic [2:0]        TypeM;
    logic              FlushW;
    logic              StallM;
    logic              RegWriteW;
    logic [ADDR_W-1:0] WA3W;
    logic [DATA_W-1:0] ResultW;
    logic [2:0]        TypeW;
    logic [31:0]       StallCount;
    logic              LoadErr;

    modport slave (
        input  ValidM, RegWriteM, MemtoRegM, ByteLoadM, WA3M, ALUOutM,
               ReadDataM, MemReadyM, TypeM, FlushW,
        output StallM, RegWriteW, WA3W, ResultW, TypeW, StallCount, LoadErr
    );

    modport master (
        output ValidM, RegWriteM, MemtoRegM, ByteLoadM, WA3M, ALUOutM,
               ReadDataM, MemReadyM, TypeM, FlushW,
        input  StallM, RegWriteW, WA3W, ResultW, TypeW, StallCount, LoadErr
    );

endinterface

// File: rtl/load_align.sv
// Load data alignment: full word, or the byte selected by addr zero-extended.
module load_align import pipeline_pkg::*; #(
    parameter int unsigned DATA_W = pipeline_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] ReadData,
    input  logic [1:0]        addr,
    input  logic              ByteLoad,
    output logic [DATA_W-1:0] data
);

    // Byte lane select and zero-extend for LDRB, pass-through otherwise
    always_comb begin
        data = ReadData;
        if (ByteLoad) begin
            data = {{(DATA_W-8){1'b0}}, ReadData[{addr, 3'b000} +: 8]};
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Memory/writeback pipeline register: captures M-stage results, drives the
// regfile write port, and stalls upstream while a load waits on memory.
module wb_stage import pipeline_pkg::*; #(
    parameter int unsigned DATA_W   = pipeline_pkg::DATA_W,
    parameter int unsigned ADDR_W   = pipeline_pkg::ADDR_W,
    parameter int unsigned MAX_WAIT = 15,
    parameter logic [2:0]  TYPE_NOP = NOP
) (
    input logic       clk,
    input logic       reset,
    wb_stage_if.slave bus
);

    wb_state_e         state;
    logic [31:0]       wait_cnt;
    logic              stall;
    logic              load_miss;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] result_m;

    logic              regwrite_q;
    logic [ADDR_W-1:0] wa3_q;
    logic [DATA_W-1:0] result_q;
    logic [2:0]        type_q;
    logic [31:0]       stall_cnt_q;
    logic              load_err_q;

    assign load_miss = bus.ValidM && bus.MemtoRegM && !bus.MemReadyM && !bus.FlushW;

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .ReadData (bus.ReadDataM),
        .addr     (bus.ALUOutM[1:0]),
        .ByteLoad (bus.ByteLoadM),
        .data     (load_data)
    );

    assign result_m = bus.MemtoRegM ? load_data : bus.ALUOutM;

    // Stall request; forced low while reset is asserted so a reset taken
    // mid-WAIT releases the front of the pipe immediately
    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    stall = load_miss;
                WAIT:    stall = !bus.MemReadyM && (wait_cnt < MAX_WAIT);
                default: stall = 1'b0;
            endcase
        end
    end

    // W-stage register, load-wait FSM and stall/error bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            regwrite_q  <= 1'b0;
            wa3_q       <= '0;
            result_q    <= '0;
            type_q      <= TYPE_NOP;
            stall_cnt_q <= '0;
            load_err_q  <= 1'b0;
        end else begin
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            case (state)
                IDLE: begin
                    if (load_miss) begin
                        state      <= WAIT;
                        wait_cnt   <= 32'd1;
                        regwrite_q <= 1'b0;
                        type_q     <= TYPE_NOP;
                    end else begin
                        regwrite_q <= bus.ValidM && bus.RegWriteM && !bus.FlushW;
                        wa3_q      <= bus.WA3M;
                        result_q   <= result_m;
                        type_q     <= (bus.ValidM && !bus.FlushW) ? bus.TypeM : TYPE_NOP;
                    end
                end
                WAIT: begin
                    if (bus.FlushW) begin
                        state      <= IDLE;
                        wait_cnt   <= '0;
                        regwrite_q <= 1'b0;
                        type_q     <= TYPE_NOP;
                    end else if (bus.MemReadyM) begin
                        state      <= IDLE;
                        wait_cnt   <= '0;
                        regwrite_q <= bus.ValidM && bus.RegWriteM;
                        wa3_q      <= bus.WA3M;
                        result_q   <= result_m;
                        type_q     <= bus.ValidM ? bus.TypeM : TYPE_NOP;
                    end else if (wait_cnt >= MAX_WAIT) begin
                        state      <= IDLE;
                        wait_cnt   <= '0;
                        regwrite_q <= 1'b0;
                        type_q     <= TYPE_NOP;
                        load_err_q <= 1'b1;
                    end else begin
                        wait_cnt   <= wait_cnt + 32'd1;
                        regwrite_q <= 1'b0;
                        type_q     <= TYPE_NOP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.StallM     = stall;
    assign bus.RegWriteW  = regwrite_q;
    assign bus.WA3W       = wa3_q;
    assign bus.ResultW    = result_q;
    assign bus.TypeW      = type_q;
    assign bus.StallCount = stall_cnt_q;
    assign bus.LoadErr    = load_err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_wb_stage;

    localparam int MAXW = 15;

    logic clk;
    logic reset;

    wb_stage_if bus ();

    wb_stage #(.MAX_WAIT(MAXW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: pend = 0 when no load is outstanding, otherwise
    // the number of cycles the load has been waiting so far.
    int          pend = 0;
    logic        e_rw;
    logic [4:0]  e_wa;
    logic [31:0] e_res;
    logic [2:0]  e_ty;
    logic [31:0] e_cnt;
    logic        e_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sel_result(input logic mtr, input logic bl,
                                               input logic [31:0] alu, input logic [31:0] rd);
        logic [1:0] lane;
        int sh;
        lane = alu[1:0];
        sh = 8 * int'(lane);
        if (mtr && bl) return (rd >> sh) & 32'h0000_00FF;
        if (mtr)       return rd;
        return alu;
    endfunction

    task automatic model_capture(input logic v, input logic rw, input logic mtr, input logic bl,
                                 input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] rd,
                                 input logic [2:0] ty, input logic fl);
        e_rw  = v && rw && !fl;
        e_wa  = wa;
        e_res = sel_result(mtr, bl, alu, rd);
        e_ty  = (v && !fl) ? ty : 3'b111;
    endtask

    task automatic model_bubble();
        e_rw = 1'b0;
        e_ty = 3'b111;
    endtask

    // One clock cycle: drive M inputs, check StallM mid-cycle, advance the
    // model at the edge, then check the registered outputs.
    task automatic step(input logic r, input logic v, input logic rw, input logic mtr,
                        input logic bl, input logic [4:0] wa, input logic [31:0] alu,
                        input logic [31:0] rd, input logic rdy, input logic [2:0] ty,
                        input logic fl);
        logic miss;
        logic exp_stall;
        reset         = r;
        bus.ValidM    = v;
        bus.RegWriteM = rw;
        bus.MemtoRegM = mtr;
        bus.ByteLoadM = bl;
        bus.WA3M      = wa;
        bus.ALUOutM   = alu;
        bus.ReadDataM = rd;
        bus.MemReadyM = rdy;
        bus.TypeM     = ty;
        bus.FlushW    = fl;
        miss = v && mtr && !rdy && !fl;
        if (r)              exp_stall = 1'b0;
        else if (pend == 0) exp_stall = miss;
        else                exp_stall = !rdy && (pend < MAXW);
        @(negedge clk);
        chk("StallM", 32'(bus.StallM), 32'(exp_stall));
        @(posedge clk);
        if (r) begin
            pend  = 0;
            e_rw  = 1'b0;
            e_wa  = '0;
            e_res = '0;
            e_ty  = 3'b111;
            e_cnt = '0;
            e_err = 1'b0;
        end else begin
            if (exp_stall) e_cnt = e_cnt + 32'd1;
            if (pend == 0) begin
                if (miss) begin
                    pend = 1;
                    model_bubble();
                end else begin
                    model_capture(v, rw, mtr, bl, wa, alu, rd, ty, fl);
                end
            end else if (fl) begin
                pend = 0;
                model_bubble();
            end else if (rdy) begin
                pend = 0;
                model_capture(v, rw, mtr, bl, wa, alu, rd, ty, fl);
            end else if (pend >= MAXW) begin
                pend  = 0;
                e_err = 1'b1;
                model_bubble();
            end else begin
                pend++;
                model_bubble();
            end
        end
        #1;
        chk("RegWriteW",  32'(bus.RegWriteW), 32'(e_rw));
        chk("WA3W",       32'(bus.WA3W),      32'(e_wa));
        chk("ResultW",    bus.ResultW,        e_res);
        chk("TypeW",      32'(bus.TypeW),     32'(e_ty));
        chk("StallCount", bus.StallCount,     e_cnt);
        chk("LoadErr",    32'(bus.LoadErr),   32'(e_err));
    endtask

    initial begin
        reset = 1'b1;
        bus.ValidM = 0; bus.RegWriteM = 0; bus.MemtoRegM = 0; bus.ByteLoadM = 0;
        bus.WA3M = '0; bus.ALUOutM = '0; bus.ReadDataM = '0; bus.MemReadyM = 1;
        bus.TypeM = '0; bus.FlushW = 0;

        // Reset state
        step(1, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 3'b000, 0);
        chk("rst_TypeW", 32'(bus.TypeW), 32'h7);
        chk("rst_RegWriteW", 32'(bus.RegWriteW), 32'h0);

        // ALU op
        step(0, 1, 1, 0, 0, 5'd5, 32'h0000_0042, 32'h0, 1, 3'b000, 0);
        chk("alu_ResultW", bus.ResultW, 32'h42);
        chk("alu_RegWriteW", 32'(bus.RegWriteW), 32'h1);

        // Byte load, lane 2
        step(0, 1, 1, 1, 1, 5'd6, 32'h0000_0102, 32'hAABB_CCDD, 1, 3'b100, 0);
        chk("ldrb_ResultW", bus.ResultW, 32'h0000_00BB);
        chk("ldrb_TypeW", 32'(bus.TypeW), 32'h4);

        // Load waits three cycles, then completes
        step(1, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 3'b000, 0);
        for (int i = 0; i < 3; i++)
            step(0, 1, 1, 1, 0, 5'd7, 32'h40, 32'h0, 0, 3'b101, 0);
        chk("wait_bubble_TypeW", 32'(bus.TypeW), 32'h7);
        step(0, 1, 1, 1, 0, 5'd7, 32'h40, 32'h1234, 1, 3'b101, 0);
        chk("wait_ResultW", bus.ResultW, 32'h1234);
        chk("wait_StallCount", bus.StallCount, 32'd3);

        // Timeout: memory never ready
        step(1, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 3'b000, 0);
        for (int i = 0; i < MAXW + 1; i++)
            step(0, 1, 1, 1, 0, 5'd9, 32'h80, 32'h0, 0, 3'b100, 0);
        chk("tmo_LoadErr", 32'(bus.LoadErr), 32'h1);
        chk("tmo_StallCount", bus.StallCount, 32'd15);
        chk("tmo_RegWriteW", 32'(bus.RegWriteW), 32'h0);
        step(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 3'b000, 0);

        // Flush during WAIT aborts the load without an error
        step(1, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 3'b000, 0);
        step(0, 1, 1, 1, 0, 5'd3, 32'h10, 32'h0, 0, 3'b100, 0);
        step(0, 1, 1, 1, 0, 5'd3, 32'h10, 32'h0, 0, 3'b100, 1);
        chk("flush_LoadErr", 32'(bus.LoadErr), 32'h0);
        step(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 3'b000, 0);

        // Reset taken mid-WAIT
        step(0, 1, 1, 1, 0, 5'd4, 32'h20, 32'h0, 0, 3'b100, 0);
        step(0, 1, 1, 1, 0, 5'd4, 32'h20, 32'h0, 0, 3'b100, 0);
        step(1, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 3'b000, 0);
        chk("rstw_StallCount", bus.StallCount, 32'd0);
        chk("rstw_TypeW", 32'(bus.TypeW), 32'h7);
        step(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 3'b000, 0);

        // Random traffic, including r0/r30 destinations and occasional resets
        for (int i = 0; i < 400; i++) begin
            logic [2:0] ty;
            logic [4:0] wa;
            case ($urandom_range(0, 4))
                0:       ty = 3'b000;
                1:       ty = 3'b001;
                2:       ty = 3'b100;
                3:       ty = 3'b101;
                default: ty = 3'b111;
            endcase
            case ($urandom_range(0, 3))
                0:       wa = 5'd0;
                1:       wa = 5'd30;
                default: wa = 5'($urandom);
            endcase
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 7) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1,
                 wa, $urandom, $urandom,
                 $urandom_range(0, 3) != 0,
                 ty,
                 $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Memory/writeback pipeline register of the 5-stage processor; sits directly upstream of the register file.
- Captures M-stage results, selects the ALU result or load data (word or zero-extended byte), and drives the regfile write port (RegWriteW, WA3W, ResultW).
- Drives the 3-bit Type code that the regfile uses for its performance counters.
- Stalls the pipeline while a load waits on data memory, and counts stall cycles.

Parameters:
- DATA_W, 32, datapath width
- ADDR_W, 5, register address width
- MAX_WAIT, 15, maximum cycles a load may wait for MemReadyM before it is aborted
- TYPE_NOP, 3'b111, Type code for bubbles; the regfile never counts it

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- ValidM  in  1  M stage holds a real instruction
- RegWriteM  in  1  instruction writes a register
- MemtoRegM  in  1  result comes from data memory
- ByteLoadM  in  1  load is a byte load (LDRB)
- WA3M  in  ADDR_W  destination register
- ALUOutM  in  DATA_W  ALU result / load address
- ReadDataM  in  DATA_W  data memory read word
- MemReadyM  in  1  ReadDataM is valid this cycle
- TypeM  in  3  instruction class code
- FlushW  in  1  discard the instruction entering W
- StallM  out  1  hold F/D/E/M stages
- RegWriteW  out  1  regfile write enable
- WA3W  out  ADDR_W  regfile write address
- ResultW  out  DATA_W  regfile write data
- TypeW  out  3  perf-counter class to regfile
- StallCount  out  32  total stall cycles
- LoadErr  out  1  sticky: a load was aborted after MAX_WAIT

Behaviour:
- Reset values: RegWriteW=0, WA3W=0, ResultW=0, TypeW=TYPE_NOP, StallCount=0, LoadErr=0, state=IDLE, wait counter=0. StallM=0 during and directly after reset.
- Outputs are registered. They update on posedge and are stable before the regfile writes on negedge. Latency is 1 cycle from capture.
- FSM states are IDLE and WAIT.
- IDLE:
  - If ValidM && MemtoRegM && !MemReadyM && !FlushW: go to WAIT, set StallM=1, load a bubble into W, and set the wait counter to 1.
  - Otherwise capture M into W.
- WAIT:
  - StallM=1. W holds a bubble every cycle.
  - If MemReadyM: capture the load into W, clear StallM combinationally in that same cycle, and go to IDLE.
  - Else if the wait counter reaches MAX_WAIT: load a bubble, set LoadErr=1, and go to IDLE.
  - Otherwise increment the wait counter.
- StallM is combinational from state and the M inputs: (IDLE && ValidM && MemtoRegM && !MemReadyM && !FlushW) || (WAIT && !MemReadyM && count<MAX_WAIT).
- Capture rules:
  - RegWriteW = ValidM && RegWriteM && !FlushW.
  - WA3W = WA3M.
  - TypeW = (ValidM && !FlushW) ? TypeM : TYPE_NOP.
- Result select:
  - If MemtoRegM && ByteLoadM: ResultW = zero-extended byte ReadDataM[8*ALUOutM[1:0] +: 8].
  - If MemtoRegM only: ResultW = ReadDataM.
  - Otherwise: ResultW = ALUOutM.
- Bubble: RegWriteW=0 and TypeW=TYPE_NOP. WA3W and ResultW keep their previous values.
- FlushW has priority over everything except reset. In WAIT it aborts the load: bubble, return to IDLE, LoadErr unchanged.
- StallCount increments by 1 on every cycle StallM=1. It wraps modulo 2^32.
- Writes to r0 and r30 are passed through unchanged; the regfile discards them.
- Reset mid-WAIT: next state is IDLE, all outputs take their reset values, and LoadErr clears.

Decomposition:
- Shared package pipeline_pkg:
  - typedef type_e: ARITH0=3'b000, ARITH1=3'b001, MEM0=3'b100, MEM1=3'b101, NOP=3'b111
  - typedef wb_state_e: IDLE, WAIT
  - localparams DATA_W, ADDR_W
- One sub-module, load_align: the combinational byte select and zero-extend (ReadData, addr[1:0], ByteLoad → data).

Test Plan:
1. ALU op: ValidM=1, RegWriteM=1, WA3M=5, ALUOutM=0x0000_0042, TypeM=000 → next cycle RegWriteW=1, WA3W=5, ResultW=0x42, TypeW=000, StallM=0.
2. Byte load: MemtoRegM=1, ByteLoadM=1, ALUOutM=0x102, ReadDataM=0xAABBCCDD, MemReadyM=1 → ResultW=0x0000_00BB, TypeW=100.
3. Load wait: MemReadyM low for 3 cycles, then high with ReadDataM=0x1234 → StallM=1 for 3 cycles, 3 bubbles (TypeW=111), then ResultW=0x1234, StallCount=3.
4. Timeout: MemReadyM never asserted, MAX_WAIT=15 → StallM high for 15 cycles, then LoadErr=1, RegWriteW=0, state IDLE.
5. Flush in WAIT: enter WAIT, assert FlushW on the 2nd cycle → next cycle StallM=0, RegWriteW=0, LoadErr=0.
6. Reset mid-WAIT: reset=1 for 1 cycle during WAIT → all outputs at reset values, StallCount=0, TypeW=111, StallM=0.
